branch_trace_stepper: RTL and testbench
=======================================

// Module: branch_trace_stepper
// PURPOSE
//  Replays a stored branch trace into the tournament predictor, one branch per divided-clock period.
//  Sits directly downstream of the clock divider: its clockOUT drives stepClk here as a slow step strobe.
//  Logic runs entirely on fast clockIN. Each step issues {PC, actual outcome} on a valid/ready handshake,
//  waits for the prediction, sends the training update, and tallies branches and mispredicts.
// PARAMETERS
//  DEPTH     64   trace entries; power of 2, >=2
//  PC_W      32   branch PC width
//  CNT_W     16   statistics counter width; counters saturate
//  LOOP      0    1: wrap to entry 0 after last entry; 0: stop in DONE
// PORTS
//  clockIN       in   1      system clock; all flops posedge clockIN
//  reset         in   1      asynchronous, active-high reset
//  stepClk       in   1      divided clock from divider (asynchronous to logic; synchronised here)
//  start         in   1      1-cycle pulse: begin replay from entry 0
//  loadEn        in   1      write trace entry (honoured only when busy=0)
//  loadAddr      in   log2(DEPTH)  trace write address
//  loadPC        in   PC_W   trace PC
//  loadTaken     in   1      trace actual outcome
//  brValid       out  1      branch record valid to predictor
//  brPC          out  PC_W   branch PC to predictor
//  brReady       in   1      predictor accepts record
//  predValid     in   1      prediction response valid (any cycle after acceptance)
//  predTaken     in   1      predicted direction
//  updValid      out  1      1-cycle training update strobe
//  updPC         out  PC_W   PC being trained
//  updTaken      out  1      actual outcome for training
//  busy          out  1      replay in progress (state not IDLE/DONE)
//  done          out  1      high in DONE until next start
//  branchCount   out  CNT_W  branches resolved
//  mispredCount  out  CNT_W  predTaken != actual
//  overrunCount  out  CNT_W  step pulses dropped
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; idx=0; counters 0; sync flops 0; pending=0; trace RAM not reset.
//  Step detect: 3-flop chain s1<-stepClk, s2<-s1, s3<-s2; stepPulse = s2 & ~s3 (one cycle per stepClk rise).
//  FSM: IDLE --start--> WAIT_STEP (counters, idx, pending cleared).
//   WAIT_STEP --stepPulse|pending--> ISSUE; pending cleared; brValid=1, brPC=trace[idx].pc registered.
//   ISSUE: hold brValid/brPC stable until brValid&brReady; then -> WAIT_PRED, brValid=0.
//   WAIT_PRED --predValid--> UPDATE: compare predTaken vs trace[idx].taken; branchCount+1; mispredCount+1 if differ.
//   UPDATE: updValid=1 exactly one cycle, updPC/updTaken = trace[idx]; then
//    idx!=DEPTH-1 -> idx+1, WAIT_STEP;  idx==DEPTH-1 & LOOP -> idx=0, WAIT_STEP;  else -> DONE.
//   DONE: done=1; start -> WAIT_STEP. start outside IDLE/DONE ignored.
//  Latency: stepClk rising before edge k => stepPulse in cycle after edge k+1 => brValid high after edge k+2.
//  Overrun: stepPulse in ISSUE/WAIT_PRED/UPDATE sets pending if clear; if pending already set, overrunCount+1.
//   Max one queued step; stepPulse in WAIT_STEP coincident with pending consumes both as one issue (no overrun).
//  predValid outside WAIT_PRED ignored. brReady only sampled while brValid=1.
//  Counters saturate at 2^CNT_W-1 (no wrap).
//  loadEn while busy=1 ignored; loadEn & start same cycle: write accepted, replay starts next cycle.
//  Async reset mid-handshake: brValid/updValid drop immediately; no partial counter update survives.
// STRUCTURE
//  Package bp_trace_pkg: typedef struct packed {logic [PC_W-1:0] pc; logic taken;} trace_rec_t;
//   typedef enum logic [2:0] {IDLE, WAIT_STEP, ISSUE, WAIT_PRED, UPDATE, DONE} stepper_state_t.
//  Sub-module step_sync_pulse: 3-flop synchroniser + rising-edge pulse (reused for any divided-clock strobe).
//  Trace RAM: DEPTH x trace_rec_t register array, synchronous write, combinational read at idx.
// TESTING
//  1 Load 4 entries {0x100,T},{0x104,N},{0x108,T},{0x10C,N}, LOOP=0, start, stepClk = clockIN/8, predictor
//    always ready, predValid 2 cycles after accept with predTaken=1 -> 4 issues, branchCount=4, mispredCount=2, done=1.
//  2 Single stepClk rise before edge k -> brValid first high after edge k+2; brPC=0x100.
//  3 brReady held 0 for 20 cycles -> brValid/brPC stable throughout; 2nd step sets pending, 3rd -> overrunCount=1;
//    after release, pending step issues entry 1 with no extra stepClk edge.
//  4 LOOP=1, DEPTH=4, 9 steps -> idx sequence 0,1,2,3,0,1,2,3,0; done never asserts; branchCount=9.
//  5 CNT_W=2 with 5 mispredicts -> mispredCount holds 3.
//  6 Assert reset while in WAIT_PRED -> all outputs 0 same cycle; later start replays from entry 0 with counters 0.

Source files
------------

// File: rtl/branch_trace_stepper_pkg.sv
// bp_trace_pkg: shared state encoding and helpers for the branch trace stepper
package bp_trace_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_STEP, ISSUE, WAIT_PRED, UPDATE, DONE} stepper_state_t;
  function automatic logic is_busy(input stepper_state_t s);
    return !(s == IDLE || s == DONE);
  endfunction
endpackage

// File: rtl/step_sync_pulse.sv
// step_sync_pulse: three-flop synchroniser with single-cycle rising-edge pulse
module step_sync_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);
  logic [2:0] sync_q;
  // shift the asynchronous strobe through s1, s2, s3
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= '0;
    else sync_q <= {sync_q[1:0], d_i};
  assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/branch_trace_stepper.sv
// branch_trace_stepper: replays a stored branch trace into a predictor, one branch per step strobe
module branch_trace_stepper
  import bp_trace_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int PC_W  = 32,
  parameter  int CNT_W = 16,
  parameter  bit LOOP  = 1'b0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clockIN,
  input  logic             reset,
  input  logic             stepClk,
  input  logic             start,
  input  logic             loadEn,
  input  logic [AW-1:0]    loadAddr,
  input  logic [PC_W-1:0]  loadPC,
  input  logic             loadTaken,
  output logic             brValid,
  output logic [PC_W-1:0]  brPC,
  input  logic             brReady,
  input  logic             predValid,
  input  logic             predTaken,
  output logic             updValid,
  output logic [PC_W-1:0]  updPC,
  output logic             updTaken,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount,
  output logic [CNT_W-1:0] overrunCount
);
  typedef struct packed {logic [PC_W-1:0] pc; logic taken;} trace_rec_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  stepper_state_t   state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d, ocnt_q, ocnt_d;
  trace_rec_t       mem_q [DEPTH];
  trace_rec_t       rec;
  logic             step_pulse, inflight, last;
  step_sync_pulse u_sync (.clk_i(clockIN), .rst_i(reset), .d_i(stepClk), .pulse_o(step_pulse));
  assign rec      = mem_q[idx_q];
  assign last     = idx_q == AW'(DEPTH - 1);
  assign inflight = state_q inside {ISSUE, WAIT_PRED, UPDATE};
  // trace RAM stays frozen during a replay so the record at idx is stable while issued
  always_ff @(posedge clockIN)
    if (loadEn && !busy) mem_q[loadAddr] <= {loadPC, loadTaken};
  // sequencing: at most one step may queue behind an in-flight branch; further steps are tallied as overruns
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    ocnt_d  = ocnt_q;
    if (inflight && step_pulse) begin
      pend_d = 1'b1;
      ocnt_d = pend_q ? sat_inc(ocnt_q) : ocnt_q;
    end
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WAIT_STEP;
        idx_d   = '0;
        pend_d  = 1'b0;
        bcnt_d  = '0;
        mcnt_d  = '0;
        ocnt_d  = '0;
      end
      WAIT_STEP: if (step_pulse || pend_q) begin
        state_d = ISSUE;
        pend_d  = 1'b0;
      end
      ISSUE: state_d = brReady ? WAIT_PRED : ISSUE;
      WAIT_PRED: if (predValid) begin
        state_d = UPDATE;
        bcnt_d  = sat_inc(bcnt_q);
        mcnt_d  = predTaken != rec.taken ? sat_inc(mcnt_q) : mcnt_q;
      end
      UPDATE: begin
        idx_d   = idx_q + 1'b1;
        state_d = last && !LOOP ? DONE : WAIT_STEP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and statistics registers
  always_ff @(posedge clockIN or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
      ocnt_q  <= ocnt_d;
    end
  assign brValid      = state_q == ISSUE;
  assign brPC         = brValid ? rec.pc : '0;
  assign updValid     = state_q == UPDATE;
  assign updPC        = updValid ? rec.pc : '0;
  assign updTaken     = updValid & rec.taken;
  assign busy         = is_busy(state_q);
  assign done         = state_q == DONE;
  assign branchCount  = bcnt_q;
  assign mispredCount = mcnt_q;
  assign overrunCount = ocnt_q;
endmodule

// File: tb/tb_branch_trace_stepper.sv
// tb_branch_trace_stepper: three stepper variants (stop, loop, loop with 2-bit counters) driven in lockstep
module tb_branch_trace_stepper;
  logic clk = 1'b0;
  logic reset = 1'b1, stepClk = 1'b0, start = 1'b0, loadEn = 1'b0, loadTaken = 1'b0;
  logic brReady = 1'b1, predValid = 1'b0, predTaken = 1'b0;
  logic [1:0] loadAddr = '0;
  logic [31:0] loadPC = '0;
  logic [2:0] br_valid, upd_valid, upd_taken, busy, done;
  logic [2:0][31:0] br_pc, upd_pc;
  logic [2:0][15:0] bc, mc, oc;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] tr_pc [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic tr_tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int cmax [3] = '{65535, 65535, 3};
  int exp_idx [3], exp_b [3], exp_m [3];
  logic last_pred = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = g == 2 ? 2 : 16;
    logic [CW-1:0] b_o, m_o, o_o;
    branch_trace_stepper #(.DEPTH(4), .PC_W(32), .CNT_W(CW), .LOOP(g != 0)) u_dut (
      .clockIN(clk), .reset(reset), .stepClk(stepClk), .start(start),
      .loadEn(loadEn), .loadAddr(loadAddr), .loadPC(loadPC), .loadTaken(loadTaken),
      .brValid(br_valid[g]), .brPC(br_pc[g]), .brReady(brReady),
      .predValid(predValid), .predTaken(predTaken),
      .updValid(upd_valid[g]), .updPC(upd_pc[g]), .updTaken(upd_taken[g]),
      .busy(busy[g]), .done(done[g]),
      .branchCount(b_o), .mispredCount(m_o), .overrunCount(o_o));
    assign bc[g] = 16'(b_o);
    assign mc[g] = 16'(m_o);
    assign oc[g] = 16'(o_o);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic step();
    stepClk = 1'b1;
    cyc(4);
    stepClk = 1'b0;
    cyc(4);
  endtask
  task automatic chk_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ctl"}, 64'({br_valid[i], upd_valid[i], upd_taken[i], busy[i], done[i]}), 64'(0));
      chk({tag, "_pc"}, {br_pc[i], upd_pc[i]}, 64'(0));
      chk({tag, "_cnt"}, 64'({bc[i], mc[i], oc[i]}), 64'(0));
    end
  endtask
  // predictor: answers 2 cycles after each accepted record, always predicting taken
  initial forever begin
    @(negedge clk);
    if (!reset && br_valid[1] && brReady) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      predValid = 1'b1;
      predTaken = 1'b1;
      last_pred = 1'b1;
      @(posedge clk); #1;
      predValid = 1'b0;
    end
  end
  // reference model: the n-th resolved branch of a replay is trace[n mod 4]; counts saturate per variant
  initial begin
    logic [2:0] pv, pacc, pupd;
    logic [2:0][31:0] ppc;
    pv = '0; pacc = '0; pupd = '0; ppc = '0;
    forever begin
      @(negedge clk);
      if (reset || start) begin
        for (int i = 0; i < 3; i++) begin
          exp_idx[i] = 0;
          exp_b[i] = 0;
          exp_m[i] = 0;
        end
        pv = '0;
        pupd = '0;
      end else begin
        chk("loop_no_done", 64'(done[2:1]), 64'(0));
        for (int i = 0; i < 3; i++) begin
          if (pv[i] && !pacc[i]) chk("br_hold", 64'({br_valid[i], br_pc[i]}), 64'({1'b1, ppc[i]}));
          if (br_valid[i]) chk("br_pc", 64'(br_pc[i]), 64'(tr_pc[exp_idx[i]]));
          if (upd_valid[i]) begin
            chk("upd_single", 64'(pupd[i]), 64'(0));
            if (exp_b[i] < cmax[i]) exp_b[i]++;
            if (last_pred != tr_tk[exp_idx[i]] && exp_m[i] < cmax[i]) exp_m[i]++;
            chk("upd_rec", 64'({upd_taken[i], upd_pc[i]}), 64'({tr_tk[exp_idx[i]], tr_pc[exp_idx[i]]}));
            chk("branch_cnt", 64'(bc[i]), 64'(exp_b[i]));
            chk("mispred_cnt", 64'(mc[i]), 64'(exp_m[i]));
            exp_idx[i] = (exp_idx[i] + 1) % 4;
          end
          pv[i] = br_valid[i];
          pacc[i] = br_valid[i] & brReady;
          ppc[i] = br_pc[i];
          pupd[i] = upd_valid[i];
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    @(negedge clk);
    chk_zero("reset");
    cyc(1);
    reset = 1'b0;
    cyc(2);
    for (int a = 0; a < 4; a++) begin
      loadEn = 1'b1;
      loadAddr = 2'(a);
      loadPC = tr_pc[a];
      loadTaken = tr_tk[a];
      start = a == 3;
      cyc(1);
    end
    loadEn = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", 64'({busy, done}), 64'(6'b111000));
    cyc(1);
    stepClk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lat_k1", 64'(br_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("lat_k2", 64'({br_valid, br_pc[0]}), 64'({3'b111, 32'h100}));
    cyc(2);
    stepClk = 1'b0;
    cyc(4);
    repeat (3) step();
    t = 0;
    while (!done[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("a_done", 64'({done[0], busy[0]}), 64'(2'b10));
    chk("a_counts", 64'({bc[0], mc[0], oc[0]}), 64'({16'd4, 16'd2, 16'd0}));
    cyc(1);
    repeat (5) step();
    cyc(4);
    chk("loop9_branches", 64'({bc[1], bc[2]}), 64'({16'd9, 16'd3}));
    chk("loop9_mispred", 64'(mc[1]), 64'(4));
    chk("a_stays_done", 64'({done[0], bc[0]}), 64'({1'b1, 16'd4}));
    step();
    cyc(4);
    chk("mispred_sat", 64'({mc[1], mc[2]}), 64'({16'd5, 16'd3}));
    chk("no_overrun", 64'({oc[0], oc[1], oc[2]}), 64'(0));
    stepClk = 1'b1;
    t = 0;
    while (!(br_valid[1] && brReady) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("issue_seen", 64'(br_valid[1]), 64'(1));
    @(posedge clk); #1;
    chk("wait_pred", 64'({busy[1], br_valid[1], upd_valid[1]}), 64'(3'b100));
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    cyc(2);
    reset = 1'b0;
    stepClk = 1'b0;
    cyc(4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    brReady = 1'b0;
    loadEn = 1'b1;
    loadAddr = 2'd0;
    loadPC = 32'hDEAD0000;
    loadTaken = 1'b0;
    cyc(1);
    loadEn = 1'b0;
    chk("restart", 64'({busy, done, bc[1], oc[1]}), 64'({3'b111, 3'b000, 32'd0}));
    repeat (3) step();
    chk("overrun", 64'({oc[0], oc[1], oc[2]}), 64'({16'd1, 16'd1, 16'd1}));
    chk("held_valid", 64'({br_valid, br_pc[1]}), 64'({3'b111, 32'h100}));
    brReady = 1'b1;
    t = 0;
    while (!upd_valid[1] && t < 12) begin
      @(negedge clk);
      t++;
    end
    chk("first_update", 64'(upd_valid[1]), 64'(1));
    t = 0;
    while (!br_valid[1] && t < 12) begin
      @(negedge clk);
      t++;
    end
    chk("pending_issue", 64'({br_valid[1], br_pc[1]}), 64'({1'b1, 32'h104}));
    cyc(10);
    chk("after_pending", 64'({bc[1], mc[1], oc[1], br_valid[1]}), 64'({16'd2, 16'd1, 16'd1, 1'b0}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
